// File: rtl/hcsr04_scan_scheduler_pkg.sv
// hcsr04_pkg: definitions shared by the HC-SR04 scan scheduler, its echo
// width timer and the existing single-sensor HC-SR04 controller.
//   - FSM state encoding of the scan scheduler
//   - default timing values and the result width
//   - saturating centimetre increment helper
package hcsr04_pkg;

    localparam int CLK_HZ_DEF     = 100_000_000;
    localparam int TICKS_PER_US   = CLK_HZ_DEF / 1_000_000;
    localparam int MAX_CM_W       = 9;
    localparam int TRIG_US_DEF    = 10;
    localparam int TIMEOUT_US_DEF = 25000;
    localparam int GAP_US_DEF     = 60000;
    localparam int US_PER_CM_DEF  = 58;
    localparam int MAX_CM_DEF     = 400;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_SELECT    = 3'd1;
    localparam state_t ST_TRIG      = 3'd2;
    localparam state_t ST_WAIT_RISE = 3'd3;
    localparam state_t ST_MEASURE   = 3'd4;
    localparam state_t ST_STORE     = 3'd5;
    localparam state_t ST_GAP       = 3'd6;

    // Increment a centimetre count, holding at the saturation value.
    function automatic logic [MAX_CM_W-1:0] cm_inc_sat(
        input logic [MAX_CM_W-1:0] cm,
        input logic [MAX_CM_W-1:0] max_cm
    );
        logic [MAX_CM_W-1:0] res;
        if (cm >= max_cm) begin
            res = max_cm;
        end else begin
            res = cm + 9'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/hcsr04_scan_scheduler_echo_width_timer.sv
// echo_width_timer: measures one echo pulse of the currently selected sensor.
// A start pulse clears and arms it. It then waits for echo_sync high, counts
// microsecond ticks while the echo is high, and converts them to centimetres
// (saturating). done rises when the echo falls or when TIMEOUT_US ticks have
// elapsed since start; timeout tells which of the two ended the slot.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   tick        : one-cycle microsecond strobe
//   echo_sync   : synchronized echo of the selected channel
//   start       : clear and arm (first cycle of the rise wait)
//   cm          : measured distance, 0..MAX_CM
//   done        : measurement finished (held until next start)
//   timeout     : measurement ended by the timeout counter
module echo_width_timer
    import hcsr04_pkg::*;
#(
    parameter int TIMEOUT_US = TIMEOUT_US_DEF,
    parameter int US_PER_CM  = US_PER_CM_DEF,
    parameter int MAX_CM     = MAX_CM_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tick,
    input  logic                echo_sync,
    input  logic                start,
    output logic [MAX_CM_W-1:0] cm,
    output logic                done,
    output logic                timeout
);

    localparam int TW = $clog2(TIMEOUT_US + 1);
    localparam int SW = $clog2(US_PER_CM + 1);

    logic                active_q, active_d;
    logic                rise_q, rise_d;
    logic [TW-1:0]       to_cnt_q, to_cnt_d;
    logic [SW-1:0]       sub_q, sub_d;
    logic [MAX_CM_W-1:0] cm_q, cm_d;
    logic                done_q, done_d;
    logic                timeout_q, timeout_d;
    logic                fall_s;
    logic                to_hit_s;

    // Next-state logic for the timeout, sub-cm and cm counters.
    always_comb begin
        active_d  = active_q;
        rise_d    = rise_q;
        to_cnt_d  = to_cnt_q;
        sub_d     = sub_q;
        cm_d      = cm_q;
        done_d    = done_q;
        timeout_d = timeout_q;
        fall_s    = active_q & rise_q & ~echo_sync;
        to_hit_s  = active_q & tick & (to_cnt_q == TW'(TIMEOUT_US - 1));
        if (start) begin
            active_d  = 1'b1;
            rise_d    = 1'b0;
            to_cnt_d  = {TW{1'b0}};
            sub_d     = {SW{1'b0}};
            cm_d      = {MAX_CM_W{1'b0}};
            done_d    = 1'b0;
            timeout_d = 1'b0;
        end else if (active_q) begin
            if (tick) begin
                to_cnt_d = to_cnt_q + TW'(1);
            end else begin
                to_cnt_d = to_cnt_q;
            end
            // The tick in the fall cycle still belongs to the pulse: the
            // measured window is exactly as long as the synced high time.
            if (rise_q && tick) begin
                if (sub_q == SW'(US_PER_CM - 1)) begin
                    sub_d = {SW{1'b0}};
                    cm_d  = cm_inc_sat(cm_q, MAX_CM_W'(MAX_CM));
                end else begin
                    sub_d = sub_q + SW'(1);
                end
            end else begin
                sub_d = sub_q;
            end
            if (!rise_q && echo_sync) begin
                rise_d = 1'b1;
            end else begin
                rise_d = rise_q;
            end
            // A fall seen on the timeout tick is a normal end, not a timeout.
            if (fall_s || to_hit_s) begin
                active_d  = 1'b0;
                done_d    = 1'b1;
                timeout_d = ~fall_s;
            end else begin
                active_d  = 1'b1;
            end
        end else begin
            active_d = 1'b0;
        end
    end

    // Timer state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            active_q  <= 1'b0;
            rise_q    <= 1'b0;
            to_cnt_q  <= {TW{1'b0}};
            sub_q     <= {SW{1'b0}};
            cm_q      <= {MAX_CM_W{1'b0}};
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            active_q  <= active_d;
            rise_q    <= rise_d;
            to_cnt_q  <= to_cnt_d;
            sub_q     <= sub_d;
            cm_q      <= cm_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
        end
    end

    assign cm      = cm_q;
    assign done    = done_q;
    assign timeout = timeout_q;

endmodule

// File: rtl/hcsr04_scan_scheduler.sv
// hcsr04_scan_scheduler: round-robin scheduler for N HC-SR04 rangers sharing
// one echo width timer. Fires a trigger at one enabled sensor at a time,
// routes its synchronized echo to the timer, publishes one tagged result per
// slot and enforces an idle gap before the next trigger.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   enable          : scanning runs while high (a running slot always completes)
//   sensor_mask     : channels taking part in the scan, sampled in SELECT
//   echo            : raw asynchronous echo pins
//   trigger         : trigger pins, at most one high
//   busy            : high in every state except IDLE
//   result_valid    : one-cycle strobe, fields hold until the next strobe
//   result_id       : channel of the result
//   result_cm       : distance in cm, 0..MAX_CM
//   result_timeout  : slot ended by timeout
module hcsr04_scan_scheduler
    import hcsr04_pkg::*;
#(
    parameter int N_SENSORS  = 4,
    parameter int CLK_HZ     = CLK_HZ_DEF,
    parameter int TRIG_US    = TRIG_US_DEF,
    parameter int TIMEOUT_US = TIMEOUT_US_DEF,
    parameter int GAP_US     = GAP_US_DEF,
    parameter int US_PER_CM  = US_PER_CM_DEF,
    parameter int MAX_CM     = MAX_CM_DEF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic [N_SENSORS-1:0]         sensor_mask,
    input  logic [N_SENSORS-1:0]         echo,
    output logic [N_SENSORS-1:0]         trigger,
    output logic                         busy,
    output logic                         result_valid,
    output logic [$clog2(N_SENSORS)-1:0] result_id,
    output logic [MAX_CM_W-1:0]          result_cm,
    output logic                         result_timeout
);

    localparam int TPU    = CLK_HZ / 1_000_000;
    localparam int PW     = $clog2(TPU);
    localparam int IW     = $clog2(N_SENSORS);
    localparam int TC_MAX = (TRIG_US > GAP_US) ? TRIG_US : GAP_US;
    localparam int CW     = $clog2(TC_MAX + 1);

    state_t                 state_q, state_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [PW-1:0]          presc_q, presc_d;
    logic [CW-1:0]          tcnt_q, tcnt_d;
    logic [N_SENSORS-1:0]   sync1_q, sync2_q;
    logic [N_SENSORS-1:0]   trigger_q, trigger_d;
    logic                   busy_q, busy_d;
    logic                   rv_q, rv_d;
    logic [IW-1:0]          rid_q, rid_d;
    logic [MAX_CM_W-1:0]    rcm_q, rcm_d;
    logic                   rto_q, rto_d;

    logic                   tick_s;
    logic                   echo_sel_s;
    logic                   start_s;
    logic                   restart_s;
    logic [IW-1:0]          next_idx_s;
    logic                   found_s;
    logic [MAX_CM_W-1:0]    tmr_cm_s;
    logic                   tmr_done_s;
    logic                   tmr_to_s;

    assign tick_s     = (presc_q == PW'(TPU - 1));
    assign echo_sel_s = sync2_q[idx_q];

    // Round robin: first set mask bit strictly after the current index,
    // wrapping; the last candidate examined is the current index itself.
    always_comb begin
        next_idx_s = idx_q;
        found_s    = 1'b0;
        for (int k = 1; k <= N_SENSORS; k++) begin
            if (!found_s && sensor_mask[(int'(idx_q) + k) % N_SENSORS]) begin
                found_s    = 1'b1;
                next_idx_s = IW'((int'(idx_q) + k) % N_SENSORS);
            end else begin
                found_s    = found_s;
            end
        end
    end

    // Scan FSM, tick counter, prescaler and output next-state logic.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tcnt_d  = tcnt_q;
        case (state_q)
            ST_IDLE: begin
                if (enable && (sensor_mask != {N_SENSORS{1'b0}})) begin
                    state_d = ST_SELECT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SELECT: begin
                idx_d   = next_idx_s;
                state_d = ST_TRIG;
            end
            ST_TRIG: begin
                if (tick_s) begin
                    if (tcnt_q == CW'(TRIG_US - 1)) begin
                        state_d = ST_WAIT_RISE;
                    end else begin
                        tcnt_d = tcnt_q + CW'(1);
                    end
                end else begin
                    tcnt_d = tcnt_q;
                end
            end
            ST_WAIT_RISE: begin
                if (tmr_done_s) begin
                    state_d = ST_STORE;
                end else if (echo_sel_s) begin
                    state_d = ST_MEASURE;
                end else begin
                    state_d = ST_WAIT_RISE;
                end
            end
            ST_MEASURE: begin
                if (tmr_done_s) begin
                    state_d = ST_STORE;
                end else begin
                    state_d = ST_MEASURE;
                end
            end
            ST_STORE: begin
                if (enable) begin
                    state_d = ST_GAP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (tick_s) begin
                    if (tcnt_q == CW'(GAP_US - 1)) begin
                        state_d = ST_IDLE;
                    end else begin
                        tcnt_d = tcnt_q + CW'(1);
                    end
                end else begin
                    tcnt_d = tcnt_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Prescaler (and tick counter) restart on entry to the timed states
        // so every timed interval starts on a fresh microsecond boundary.
        restart_s = (state_d != state_q) &&
                    ((state_d == ST_TRIG) || (state_d == ST_WAIT_RISE) || (state_d == ST_GAP));
        start_s   = (state_d != state_q) && (state_d == ST_WAIT_RISE);
        if (restart_s) begin
            presc_d = {PW{1'b0}};
            tcnt_d  = {CW{1'b0}};
        end else if (tick_s) begin
            presc_d = {PW{1'b0}};
        end else begin
            presc_d = presc_q + PW'(1);
        end

        // Outputs are registered from the next state so they line up with it.
        trigger_d = {N_SENSORS{1'b0}};
        if (state_d == ST_TRIG) begin
            trigger_d[idx_d] = 1'b1;
        end else begin
            trigger_d = {N_SENSORS{1'b0}};
        end
        busy_d = (state_d != ST_IDLE);
        rv_d   = (state_d == ST_STORE);
        if (state_d == ST_STORE) begin
            rid_d = idx_q;
            rcm_d = tmr_cm_s;
            rto_d = tmr_to_s;
        end else begin
            rid_d = rid_q;
            rcm_d = rcm_q;
            rto_d = rto_q;
        end
    end

    // Echo synchronizers, FSM state and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            idx_q     <= IW'(N_SENSORS - 1);
            presc_q   <= {PW{1'b0}};
            tcnt_q    <= {CW{1'b0}};
            sync1_q   <= {N_SENSORS{1'b0}};
            sync2_q   <= {N_SENSORS{1'b0}};
            trigger_q <= {N_SENSORS{1'b0}};
            busy_q    <= 1'b0;
            rv_q      <= 1'b0;
            rid_q     <= {IW{1'b0}};
            rcm_q     <= {MAX_CM_W{1'b0}};
            rto_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            presc_q   <= presc_d;
            tcnt_q    <= tcnt_d;
            sync1_q   <= echo;
            sync2_q   <= sync1_q;
            trigger_q <= trigger_d;
            busy_q    <= busy_d;
            rv_q      <= rv_d;
            rid_q     <= rid_d;
            rcm_q     <= rcm_d;
            rto_q     <= rto_d;
        end
    end

    echo_width_timer #(
        .TIMEOUT_US (TIMEOUT_US),
        .US_PER_CM  (US_PER_CM),
        .MAX_CM     (MAX_CM)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick_s),
        .echo_sync (echo_sel_s),
        .start     (start_s),
        .cm        (tmr_cm_s),
        .done      (tmr_done_s),
        .timeout   (tmr_to_s)
    );

    assign trigger        = trigger_q;
    assign busy           = busy_q;
    assign result_valid   = rv_q;
    assign result_id      = rid_q;
    assign result_cm      = rcm_q;
    assign result_timeout = rto_q;

endmodule

// File: tb/tb_hcsr04_scan_scheduler.sv
// Bench for hcsr04_scan_scheduler with shortened timing: 2 clocks per us,
// TIMEOUT 2000 us, GAP 50 us, 58 us/cm, saturation at 20 cm.
module tb_hcsr04_scan_scheduler;

    localparam int TPU     = 2;
    localparam int TRIG_US = 10;
    localparam int TO_US   = 2000;
    localparam int GAP_US  = 50;
    localparam int NV      = 11;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [3:0] sensor_mask;
    logic [3:0] echo;
    logic [3:0] trigger;
    logic       busy;
    logic       result_valid;
    logic [1:0] result_id;
    logic [8:0] result_cm;
    logic       result_timeout;

    int errors = 0;
    int checks = 0;
    int onehot_err = 0;
    int t2_cnt = 0;

    typedef struct {
        logic [3:0] mask;
        int         delay_us;
        int         width_us;
        bit         stuck;
        int         exp_id;
        int         exp_cm;
        int         exp_to;
    } vec_t;

    vec_t vecs [NV];

    hcsr04_scan_scheduler #(
        .N_SENSORS  (4),
        .CLK_HZ     (2_000_000),
        .TRIG_US    (TRIG_US),
        .TIMEOUT_US (TO_US),
        .GAP_US     (GAP_US),
        .US_PER_CM  (58),
        .MAX_CM     (20)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .sensor_mask    (sensor_mask),
        .echo           (echo),
        .trigger        (trigger),
        .busy           (busy),
        .result_valid   (result_valid),
        .result_id      (result_id),
        .result_cm      (result_cm),
        .result_timeout (result_timeout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if ($countones(trigger) > 1) onehot_err++;
        if (trigger[2]) t2_cnt++;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic wait_trig(input string name, output int ch, output int cyc);
        cyc = 0;
        while (trigger == 4'b0000 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        chk({name, " trigger seen"}, int'(|trigger), 1);
        ch = 0;
        for (int b = 0; b < 4; b++) begin
            if (trigger[b]) ch = b;
        end
    endtask

    task automatic wait_valid(input string name, output int cyc);
        cyc = 0;
        while (!result_valid && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        chk({name, " result_valid seen"}, int'(result_valid), 1);
    endtask

    initial begin
        int ch, gap, hi, cyc, tcount;
        string nm;

        //           mask     dly  width stuck id cm to
        vecs[0]  = '{4'b1011, 300, 580,  1'b0, 0, 10, 0};
        vecs[1]  = '{4'b1011, 50,  140,  1'b0, 1, 2,  0};
        vecs[2]  = '{4'b1011, 20,  300,  1'b0, 3, 5,  0};
        vecs[3]  = '{4'b1011, 10,  57,   1'b0, 0, 0,  0};
        vecs[4]  = '{4'b1011, 10,  58,   1'b0, 1, 1,  0};
        vecs[5]  = '{4'b1011, 100, 1300, 1'b0, 3, 20, 0};
        vecs[6]  = '{4'b0001, 0,   1159, 1'b0, 0, 19, 0};
        vecs[7]  = '{4'b0001, 5,   1160, 1'b0, 0, 20, 0};
        vecs[8]  = '{4'b0001, 0,   0,    1'b0, 0, 0,  1};
        vecs[9]  = '{4'b0011, 30,  200,  1'b0, 1, 3,  0};
        vecs[10] = '{4'b0010, 0,   0,    1'b1, 1, 20, 1};

        reset = 1'b1;
        enable = 1'b0;
        sensor_mask = 4'b0000;
        echo = 4'b0000;
        repeat (3) @(negedge clk);
        chk("reset trigger", int'(trigger), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset result_valid", int'(result_valid), 0);
        chk("reset result_id", int'(result_id), 0);
        chk("reset result_cm", int'(result_cm), 0);
        chk("reset result_timeout", int'(result_timeout), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle busy with enable low", int'(busy), 0);

        sensor_mask = vecs[0].mask;
        enable = 1'b1;
        for (int i = 0; i < NV; i++) begin
            nm = $sformatf("v%0d", i);
            wait_trig(nm, ch, gap);
            chk({nm, " trigger channel"}, ch, vecs[i].exp_id);
            if (i > 0) chk_rng({nm, " result to next trigger"}, gap, 102, 104);
            if (vecs[i].stuck) echo[ch] = 1'b1;
            hi = 0;
            while (trigger != 4'b0000 && hi < 1000) begin
                hi++;
                @(negedge clk);
            end
            chk({nm, " trigger width"}, hi, TRIG_US * TPU);
            if (vecs[i].width_us > 0 && !vecs[i].stuck) begin
                repeat (vecs[i].delay_us * TPU) @(negedge clk);
                echo[ch] = 1'b1;
                repeat (vecs[i].width_us * TPU) @(negedge clk);
                echo[ch] = 1'b0;
            end
            wait_valid(nm, cyc);
            if (vecs[i].exp_to != 0) chk_rng({nm, " fall to timeout result"}, cyc, TO_US * TPU, TO_US * TPU + 3);
            chk({nm, " result_id"}, int'(result_id), vecs[i].exp_id);
            chk({nm, " result_cm"}, int'(result_cm), vecs[i].exp_cm);
            chk({nm, " result_timeout"}, int'(result_timeout), vecs[i].exp_to);
            echo = 4'b0000;
            if (i < NV - 1) sensor_mask = vecs[i + 1].mask;
        end

        // Enable dropped during MEASURE: slot still reports, then idle.
        sensor_mask = 4'b0001;
        wait_trig("endrop", ch, gap);
        chk("endrop trigger channel", ch, 0);
        hi = 0;
        while (trigger != 4'b0000 && hi < 1000) begin
            hi++;
            @(negedge clk);
        end
        repeat (10 * TPU) @(negedge clk);
        echo[ch] = 1'b1;
        repeat (400 * TPU) @(negedge clk);
        enable = 1'b0;
        repeat (400 * TPU) @(negedge clk);
        echo[ch] = 1'b0;
        wait_valid("endrop", cyc);
        chk("endrop result_id", int'(result_id), 0);
        chk("endrop result_cm", int'(result_cm), 13);
        chk("endrop result_timeout", int'(result_timeout), 0);
        chk("endrop busy at strobe", int'(busy), 1);
        @(negedge clk);
        chk("endrop busy after strobe", int'(busy), 0);
        tcount = 0;
        repeat (300) begin
            @(negedge clk);
            if (trigger != 4'b0000) tcount++;
        end
        chk("endrop no further trigger", tcount, 0);
        chk("endrop result fields held", int'(result_cm), 13);

        // Reset during TRIG, then the scan restarts at channel 0.
        sensor_mask = 4'b1011;
        enable = 1'b1;
        wait_trig("rst", ch, gap);
        chk("rst pre-reset channel", ch, 1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst trigger low", int'(trigger), 0);
        chk("rst busy low", int'(busy), 0);
        chk("rst result_cm cleared", int'(result_cm), 0);
        @(negedge clk);
        reset = 1'b0;
        wait_trig("rst post", ch, gap);
        chk("rst first channel after release", ch, 0);

        chk("at most one trigger high", onehot_err, 0);
        chk("trigger[2] never asserted", t2_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
